// File: rtl/nfc_pkg.sv
// Shared command codes, state encoding and address widths for the NAND flash port.
package nfc_pkg;

    localparam int unsigned PAGE_W = 9;
    localparam int unsigned COL_W  = 9;
    localparam int unsigned ADDR_W = PAGE_W + COL_W;
    localparam int unsigned CNT_W  = 5;

    localparam logic [7:0] CMD_READ0   = 8'h00;
    localparam logic [7:0] CMD_READ1   = 8'h01;
    localparam logic [7:0] CMD_PROG    = 8'h80;
    localparam logic [7:0] CMD_CONFIRM = 8'h10;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD_BUSY,
        RD_DATA,
        WR_DATA,
        PROG_BUSY,
        RST_BUSY
    } nfc_state_e;

endpackage

// File: rtl/nand_busy_timer.sv
// Loadable down-counter; busy is a flop that stays high for exactly len cycles after load.
module nand_busy_timer
    import nfc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             busy
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            cnt  <= len;
            busy <= (len != '0);
        end else if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            busy <= (cnt != CNT_W'(1));
        end
    end

endmodule

// File: rtl/nand_flash_port.sv
// Device-side NAND channel front end: CLE/ALE/WEN/REN byte decode, ready/busy
// handshake and page-array memory access for one chip.
module nand_flash_port
    import nfc_pkg::*;
#(
    parameter int unsigned T_R    = 8,
    parameter int unsigned T_PROG = 16,
    parameter int unsigned T_RST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [7:0]        F_IO,
    input  logic              F_CLE,
    input  logic              F_ALE,
    input  logic              F_WEN,
    input  logic              F_REN,
    output logic              F_RB,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    nfc_state_e        state, state_nxt;
    logic              wen_q, ren_q;
    logic [PAGE_W-1:0] page, page_nxt;
    logic [COL_W-1:0]  col, col_nxt, col_base, col_base_nxt;
    logic [1:0]        addr_cnt, addr_cnt_nxt;
    logic              rd_pend, rd_pend_nxt;
    logic              rd_mode, rd_mode_nxt;
    logic [7:0]        dout_reg, dout_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [7:0]        mem_wdata_nxt;
    logic              mem_we_nxt;
    logic              load_c, busy;
    logic [CNT_W-1:0]  len_c;
    logic              wen_evt_c, ren_evt_c, is_cmd_c, is_addr_c, is_data_c, busy_st_c;

    nand_busy_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .len  (len_c),
        .busy (busy)
    );

    assign F_RB = ~busy;
    assign F_IO = (rd_mode && !F_REN) ? dout_reg : 8'hzz;

    assign wen_evt_c = F_WEN && !wen_q;
    assign ren_evt_c = F_REN && !ren_q;
    assign is_cmd_c  = wen_evt_c &&  F_CLE && !F_ALE;
    assign is_addr_c = wen_evt_c && !F_CLE &&  F_ALE;
    assign is_data_c = wen_evt_c && !F_CLE && !F_ALE;
    assign busy_st_c = (state == RD_BUSY) || (state == PROG_BUSY) || (state == RST_BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wen_q     <= 1'b1;
            ren_q     <= 1'b1;
            page      <= '0;
            col       <= '0;
            col_base  <= '0;
            addr_cnt  <= '0;
            rd_pend   <= 1'b0;
            rd_mode   <= 1'b0;
            dout_reg  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            state     <= state_nxt;
            wen_q     <= F_WEN;
            ren_q     <= F_REN;
            page      <= page_nxt;
            col       <= col_nxt;
            col_base  <= col_base_nxt;
            addr_cnt  <= addr_cnt_nxt;
            rd_pend   <= rd_pend_nxt;
            rd_mode   <= rd_mode_nxt;
            dout_reg  <= dout_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_we    <= mem_we_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        page_nxt      = page;
        col_nxt       = col;
        col_base_nxt  = col_base;
        addr_cnt_nxt  = addr_cnt;
        rd_pend_nxt   = rd_pend;
        rd_mode_nxt   = rd_mode;
        dout_nxt      = dout_reg;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_we_nxt    = 1'b0;
        load_c        = 1'b0;
        len_c         = '0;

        case (state)
            ADDR: begin
                if (is_addr_c) begin
                    case (addr_cnt)
                        2'd0: begin
                            col_nxt      = col_base + COL_W'(F_IO);
                            addr_cnt_nxt = 2'd1;
                        end
                        2'd1: begin
                            page_nxt[7:0] = F_IO;
                            addr_cnt_nxt  = 2'd2;
                        end
                        default: begin
                            page_nxt[8]  = F_IO[0];
                            addr_cnt_nxt = 2'd0;
                            if (rd_pend) begin
                                state_nxt = RD_BUSY;
                                load_c    = 1'b1;
                                len_c     = CNT_W'(T_R);
                            end else begin
                                state_nxt = WR_DATA;
                            end
                        end
                    endcase
                end
            end
            // Prefetch the first byte while the busy window runs.
            RD_BUSY: begin
                mem_addr_nxt = {page, col};
                dout_nxt     = mem_rdata;
                if (!busy) begin
                    state_nxt   = RD_DATA;
                    rd_mode_nxt = 1'b1;
                end
            end
            RD_DATA: begin
                if (ren_evt_c) begin
                    col_nxt = col + COL_W'(1);
                end
                mem_addr_nxt = {page, col_nxt};
                dout_nxt     = mem_rdata;
            end
            WR_DATA: begin
                if (is_data_c) begin
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = {page, col};
                    mem_wdata_nxt = F_IO;
                    col_nxt       = col + COL_W'(1);
                end
            end
            PROG_BUSY, RST_BUSY: begin
                if (!busy) begin
                    state_nxt = IDLE;
                end
            end
            default: ;
        endcase

        // Commands override the per-state behaviour; only reset breaks a busy window.
        if (is_cmd_c) begin
            if (F_IO == CMD_RESET) begin
                state_nxt    = RST_BUSY;
                rd_mode_nxt  = 1'b0;
                addr_cnt_nxt = 2'd0;
                load_c       = 1'b1;
                len_c        = CNT_W'(T_RST);
            end else if (!busy_st_c) begin
                rd_mode_nxt = 1'b0;
                case (F_IO)
                    CMD_READ0, CMD_READ1: begin
                        col_base_nxt = (F_IO == CMD_READ1) ? COL_W'(256) : '0;
                        rd_pend_nxt  = 1'b1;
                        addr_cnt_nxt = 2'd0;
                        state_nxt    = ADDR;
                    end
                    CMD_PROG: begin
                        rd_pend_nxt  = 1'b0;
                        addr_cnt_nxt = 2'd0;
                        state_nxt    = ADDR;
                    end
                    CMD_CONFIRM: begin
                        if (state == WR_DATA) begin
                            state_nxt = PROG_BUSY;
                            load_c    = 1'b1;
                            len_c     = CNT_W'(T_PROG);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nand_flash_port.sv
// Scoreboard bench for nand_flash_port: two ports (A and B) with behavioural page memories.
module tb_nand_flash_port;

    localparam int unsigned AW    = 18;
    localparam int unsigned MEM_N = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cle [2];
    logic       ale [2];
    logic       wen [2];
    logic       ren [2];
    logic       drv [2];
    logic [7:0] tb_io [2];

    wire  [7:0] f_io_a, f_io_b;
    assign f_io_a = drv[0] ? tb_io[0] : 8'hzz;
    assign f_io_b = drv[1] ? tb_io[1] : 8'hzz;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
        pullup (f_io_a[gi]);
        pullup (f_io_b[gi]);
    end

    logic          rb_a, rb_b, mem_we_a, mem_we_b;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [7:0]    mem_wdata_a, mem_wdata_b, rdata_a, rdata_b;

    nand_flash_port u_a (
        .clk(clk), .rst(rst), .F_IO(f_io_a), .F_CLE(cle[0]), .F_ALE(ale[0]),
        .F_WEN(wen[0]), .F_REN(ren[0]), .F_RB(rb_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .mem_rdata(rdata_a)
    );

    nand_flash_port u_b (
        .clk(clk), .rst(rst), .F_IO(f_io_b), .F_CLE(cle[1]), .F_ALE(ale[1]),
        .F_WEN(wen[1]), .F_REN(ren[1]), .F_RB(rb_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rdata(rdata_b)
    );

    logic [7:0]    mem_a [MEM_N];
    logic [7:0]    mem_b [MEM_N];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [7:0]    pre_data = '0;

    always @(posedge clk) begin
        if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
        if (pre_we)   mem_a[pre_addr]   <= pre_data;
        rdata_a <= mem_a[mem_addr_a];
    end

    always @(posedge clk) begin
        if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
        rdata_b <= mem_b[mem_addr_b];
    end

    int we_cnt_a = 0;
    int we_cnt_b = 0;
    always @(negedge clk) begin
        if (mem_we_a) we_cnt_a++;
        if (mem_we_b) we_cnt_b++;
    end

    int         n_chk = 0;
    int         n_fail = 0;
    wr_t        wq [$];
    logic [7:0] rq [$];

    function automatic logic rbv(input int p);
        return (p == 1) ? rb_b : rb_a;
    endfunction

    function automatic logic [7:0] pat(input int pg, input int c);
        return 8'(c * 7 + pg * 11 + 3);
    endfunction

    task automatic wr_byte(input int p, input logic c, input logic a, input logic [7:0] d);
        @(posedge clk); #1;
        cle[p] = c; ale[p] = a; tb_io[p] = d; drv[p] = 1'b1; wen[p] = 1'b0;
        @(posedge clk); #1;
        wen[p] = 1'b1;
        @(posedge clk); #1;
        drv[p] = 1'b0; cle[p] = 1'b0; ale[p] = 1'b0;
    endtask

    task automatic cmd(input int p, input logic [7:0] d); wr_byte(p, 1'b1, 1'b0, d); endtask
    task automatic adr(input int p, input logic [7:0] d); wr_byte(p, 1'b0, 1'b1, d); endtask
    task automatic dat(input int p, input logic [7:0] d); wr_byte(p, 1'b0, 1'b0, d); endtask

    task automatic rd_byte(input int p, output logic [7:0] d);
        @(posedge clk); #1;
        ren[p] = 1'b0;
        @(negedge clk);
        d = (p == 1) ? f_io_b : f_io_a;
        @(posedge clk); #1;
        ren[p] = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_rb(input int p, output int low);
        bit seen;
        seen = 1'b0;
        low = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rbv(p) == 1'b0) begin
                low++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
    endtask

    task automatic preload(input int pg, input int mul, input int add);
        for (int c = 0; c < 512; c++) begin
            @(posedge clk); #1;
            pre_we = 1'b1; pre_addr = AW'(pg * 512 + c); pre_data = 8'(c * mul + add);
        end
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ren[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (rb_a !== 1'b1 || mem_we_a !== 1'b0 || mem_addr_a !== '0 || mem_wdata_a !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rb=%b we=%b addr=%h wdata=%h, expected rb=1 we=0 addr=0 wdata=0",
                     rb_a, mem_we_a, mem_addr_a, mem_wdata_a);
        end
        n_chk++;
        if (f_io_a !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_fio_hiz: f_io=%h, expected ff (undriven)", f_io_a);
        end
        ren[0] = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (rb_a !== 1'b1 || rb_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_rb: rb_a=%b rb_b=%b, expected 1 1", rb_a, rb_b);
        end
    endtask

    task automatic test_program();
        int  low, w0;
        wr_t e;
        w0 = we_cnt_a;
        cmd(0, 8'h80); adr(0, 8'h00); adr(0, 8'h05); adr(0, 8'h01);
        for (int i = 0; i < 512; i++) begin
            e.a = AW'(18'h20A00 + i); e.d = 8'(i);
            wq.push_back(e);
            dat(0, 8'(i));
            e = wq.pop_front();
            n_chk++;
            if (mem_we_a !== 1'b1 || mem_addr_a !== e.a || mem_wdata_a !== e.d) begin
                n_fail++;
                $display("FAIL prog_write[%0d]: we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                         i, mem_we_a, mem_addr_a, mem_wdata_a, e.a, e.d);
            end
        end
        wr_byte(0, 1'b1, 1'b1, 8'h10);
        n_chk++;
        if (mem_we_a !== 1'b0 || rb_a !== 1'b1) begin
            n_fail++;
            $display("FAIL cle_ale_both_ignored: we=%b rb=%b, expected we=0 rb=1", mem_we_a, rb_a);
        end
        cmd(0, 8'h10);
        wait_rb(0, low);
        n_chk++;
        if (low != 16) begin
            n_fail++;
            $display("FAIL prog_busy_len: rb low %0d cycles, expected 16", low);
        end
        n_chk++;
        if (we_cnt_a - w0 != 512) begin
            n_fail++;
            $display("FAIL prog_we_count: %0d pulses, expected 512", we_cnt_a - w0);
        end
    endtask

    task automatic test_read();
        int         low;
        logic [7:0] d, e;
        preload(3, 1, 0);
        preload(4, 0, 8'hA5);
        cmd(0, 8'h01); adr(0, 8'h10); adr(0, 8'h03); adr(0, 8'h00);
        wait_rb(0, low);
        n_chk++;
        if (low != 8) begin
            n_fail++;
            $display("FAIL read_busy_len: rb low %0d cycles, expected 8", low);
        end
        for (int i = 0; i < 244; i++) begin
            rq.push_back(8'((272 + i) % 512));
            rd_byte(0, d);
            e = rq.pop_front();
            n_chk++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL read_byte[%0d]: got %h, expected %h", i, d, e);
            end
        end
    endtask

    task automatic test_prog_wrap();
        int  low;
        wr_t e;
        cmd(0, 8'h01);
        cmd(0, 8'h80); adr(0, 8'hFE); adr(0, 8'h07); adr(0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            e.a = AW'(7 * 512 + ((510 + i) % 512)); e.d = 8'(8'hC0 + i);
            wq.push_back(e);
            dat(0, 8'(8'hC0 + i));
            e = wq.pop_front();
            n_chk++;
            if (mem_we_a !== 1'b1 || mem_addr_a !== e.a || mem_wdata_a !== e.d) begin
                n_fail++;
                $display("FAIL wrap_write[%0d]: we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                         i, mem_we_a, mem_addr_a, mem_wdata_a, e.a, e.d);
            end
        end
        cmd(0, 8'h10);
        wait_rb(0, low);
        n_chk++;
        if (low != 16) begin
            n_fail++;
            $display("FAIL wrap_busy_len: rb low %0d cycles, expected 16", low);
        end
    endtask

    task automatic test_reset_abort();
        int         low, w0;
        wr_t        e;
        logic [7:0] d, x;
        cmd(0, 8'h00);
        cmd(0, 8'h80); adr(0, 8'h00); adr(0, 8'h02); adr(0, 8'h00);
        for (int i = 0; i < 100; i++) begin
            e.a = AW'(2 * 512 + i); e.d = 8'(i * 3);
            wq.push_back(e);
            dat(0, 8'(i * 3));
            e = wq.pop_front();
            n_chk++;
            if (mem_we_a !== 1'b1 || mem_addr_a !== e.a || mem_wdata_a !== e.d) begin
                n_fail++;
                $display("FAIL abort_write[%0d]: we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                         i, mem_we_a, mem_addr_a, mem_wdata_a, e.a, e.d);
            end
        end
        cmd(0, 8'hFF);
        w0 = we_cnt_a;
        wait_rb(0, low);
        n_chk++;
        if (low != 4) begin
            n_fail++;
            $display("FAIL reset_busy_len: rb low %0d cycles, expected 4", low);
        end
        for (int i = 0; i < 5; i++) dat(0, 8'h5A);
        repeat (2) @(negedge clk);
        n_chk++;
        if (we_cnt_a != w0) begin
            n_fail++;
            $display("FAIL abort_no_write: %0d extra pulses, expected 0", we_cnt_a - w0);
        end
        cmd(0, 8'h00); adr(0, 8'h00); adr(0, 8'h02); adr(0, 8'h00);
        wait_rb(0, low);
        n_chk++;
        if (low != 8) begin
            n_fail++;
            $display("FAIL abort_read_busy: rb low %0d cycles, expected 8", low);
        end
        for (int i = 0; i < 4; i++) begin
            rq.push_back(8'(i * 3));
            rd_byte(0, d);
            x = rq.pop_front();
            n_chk++;
            if (d !== x) begin
                n_fail++;
                $display("FAIL abort_read[%0d]: got %h, expected %h", i, d, x);
            end
        end
    endtask

    task automatic test_async_reset();
        int low;
        cmd(0, 8'h80); adr(0, 8'h00); adr(0, 8'h08); adr(0, 8'h00);
        dat(0, 8'h11); dat(0, 8'h22);
        cmd(0, 8'h10);
        repeat (3) @(negedge clk);
        n_chk++;
        if (rb_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_pre_busy: rb=%b, expected 0", rb_a);
        end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (rb_a !== 1'b1 || mem_we_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rb: rb=%b we=%b, expected rb=1 we=0 before any clk edge", rb_a, mem_we_a);
        end
        @(negedge clk);
        rst = 1'b1;
        cmd(0, 8'h10);
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rb_a == 1'b0) low++;
        end
        n_chk++;
        if (low != 0) begin
            n_fail++;
            $display("FAIL confirm_after_reset: rb low %0d cycles, expected 0", low);
        end
        cmd(0, 8'h00); adr(0, 8'h00); adr(0, 8'h03); adr(0, 8'h00);
        wait_rb(0, low);
        repeat (2) @(posedge clk);
        #1 ren[0] = 1'b0;
        @(negedge clk);
        n_chk++;
        if (f_io_a !== 8'h00) begin
            n_fail++;
            $display("FAIL async_read_drive: f_io=%h, expected 00", f_io_a);
        end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (f_io_a !== 8'hFF) begin
            n_fail++;
            $display("FAIL async_fio_hiz: f_io=%h, expected ff (undriven) before any clk edge", f_io_a);
        end
        ren[0] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int         low, bad, w0;
        logic [7:0] d, e;
        preload(0, 7, 3);
        preload(1, 7, 14);
        w0 = we_cnt_b;
        for (int pg = 0; pg < 2; pg++) begin
            cmd(0, 8'h00); adr(0, 8'h00); adr(0, 8'(pg)); adr(0, 8'h00);
            wait_rb(0, low);
            n_chk++;
            if (low != 8) begin
                n_fail++;
                $display("FAIL copy_read_busy[%0d]: rb low %0d cycles, expected 8", pg, low);
            end
            cmd(1, 8'h80); adr(1, 8'h00); adr(1, 8'(pg)); adr(1, 8'h00);
            for (int c = 0; c < 512; c++) begin
                rq.push_back(pat(pg, c));
                rd_byte(0, d);
                e = rq.pop_front();
                n_chk++;
                if (d !== e) begin
                    n_fail++;
                    $display("FAIL copy_read[%0d][%0d]: got %h, expected %h", pg, c, d, e);
                end
                dat(1, d);
            end
            cmd(1, 8'h10);
            wait_rb(1, low);
            n_chk++;
            if (low != 16) begin
                n_fail++;
                $display("FAIL copy_prog_busy[%0d]: rb low %0d cycles, expected 16", pg, low);
            end
        end
        n_chk++;
        if (we_cnt_b - w0 != 1024) begin
            n_fail++;
            $display("FAIL copy_we_count: %0d pulses, expected 1024", we_cnt_b - w0);
        end
        for (int pg = 0; pg < 2; pg++) begin
            bad = 0;
            for (int c = 0; c < 512; c++) begin
                if (mem_b[AW'(pg * 512 + c)] !== pat(pg, c)) bad++;
            end
            n_chk++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL copy_page[%0d]: %0d bytes differ, expected 0", pg, bad);
            end
        end
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            cle[p] = 1'b0; ale[p] = 1'b0; wen[p] = 1'b1; ren[p] = 1'b1;
            drv[p] = 1'b0; tb_io[p] = 8'h00;
        end
        rst = 1'b0;
        test_reset();
        test_program();
        test_read();
        test_prog_wrap();
        test_reset_abort();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d checks done", n_chk);
        $fatal(1, "timeout");
    end

endmodule
